// File: rtl/bk16_mp_pkg.sv
// Shared types and helpers for the bk16 multi-precision add sequencer.
package bk16_mp_pkg;

    localparam int unsigned WORD_W    = 16;
    localparam int unsigned MAX_WORDS = 16;

    typedef enum logic [1:0] {IDLE, ADD, INC, DONE} state_t;

    // Callers zero-extend their operand to the full MAX_WORDS width.
    function automatic logic [WORD_W-1:0] word_sel(input logic [WORD_W*MAX_WORDS-1:0] vec,
                                                   input logic [3:0]                  idx);
        return vec[idx*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/bk16.sv
// 16-bit Brent-Kung adder without carry-in.
module bk16 (
    output logic [15:0] Sum,
    output logic        Cout,
    input  logic [15:0] A,
    input  logic [15:0] B
);

    logic [15:0] w_h;
    logic [15:0] w_g;
    logic [15:0] w_p;

    always_comb begin
        w_h = A ^ B;
        w_g = A & B;
        w_p = A ^ B;
        // Up-sweep: node i absorbs the span ending at i - 2^l.
        for (int l = 0; l < 4; l++) begin
            for (int i = 0; i < 16; i++) begin
                if (((i + 1) % (2 ** (l + 1))) == 0) begin
                    w_g[i] = w_g[i] | (w_p[i] & w_g[4'(i - (2 ** l))]);
                    w_p[i] = w_p[i] & w_p[4'(i - (2 ** l))];
                end
            end
        end
        // Down-sweep fills in the remaining prefixes.
        for (int l = 2; l >= 0; l--) begin
            for (int i = 0; i < 16; i++) begin
                if ((((i + 1) % (2 ** (l + 1))) == (2 ** l)) && (i >= (2 ** (l + 1)))) begin
                    w_g[i] = w_g[i] | (w_p[i] & w_g[4'(i - (2 ** l))]);
                    w_p[i] = w_p[i] & w_p[4'(i - (2 ** l))];
                end
            end
        end
        Sum[0] = w_h[0];
        for (int i = 1; i < 16; i++) begin
            Sum[i] = w_h[i] ^ w_g[4'(i - 1)];
        end
        Cout = w_g[15];
    end

endmodule

// File: rtl/bk16_mp_seq.sv
// Multi-precision adder sequencing one shared bk16 over WORDS 16-bit words, LSW first.
// Optional macro BK16_SKIP_INC_EN skips the INC phase for words entered with carry=0.
module bk16_mp_seq
    import bk16_mp_pkg::*;
#(
    parameter int unsigned WORDS = 4
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [WORD_W*WORDS-1:0] A,
    input  logic [WORD_W*WORDS-1:0] B,
    input  logic                  Cin,
    output logic                  Busy,
    output logic                  Done,
    output logic [WORD_W*WORDS-1:0] Sum,
    output logic                  Cout
);

    localparam int unsigned W = WORD_W * WORDS;

    state_t                   r_state;
    state_t                   w_state_d;
    logic [W-1:0]             r_a;
    logic [W-1:0]             r_b;
    logic [W-1:0]             r_work;
    logic [W-1:0]             r_sum;
    logic [3:0]               r_idx;
    logic                     r_carry;
    logic                     r_c1;
    logic                     r_cout;
    logic [WORD_W-1:0]        r_t;
    logic [WORD_W*MAX_WORDS-1:0] w_a_ext;
    logic [WORD_W*MAX_WORDS-1:0] w_b_ext;
    logic [WORD_W-1:0]        w_add_a;
    logic [WORD_W-1:0]        w_add_b;
    logic [WORD_W-1:0]        w_sum16;
    logic                     w_cout16;
    logic                     w_last;
    logic                     w_skip;

    bk16 u_bk16 (
        .Sum  (w_sum16),
        .Cout (w_cout16),
        .A    (w_add_a),
        .B    (w_add_b)
    );

`ifdef BK16_SKIP_INC_EN
    assign w_skip = ~r_carry;
`else
    assign w_skip = 1'b0;
`endif

    assign w_last = (r_idx == 4'(WORDS - 1));
    assign Busy   = (r_state != IDLE);
    assign Done   = (r_state == DONE);
    assign Sum    = r_sum;
    assign Cout   = r_cout;

    always_comb begin
        w_a_ext        = '0;
        w_b_ext        = '0;
        w_a_ext[W-1:0] = r_a;
        w_b_ext[W-1:0] = r_b;
        w_add_a        = word_sel(w_a_ext, r_idx);
        w_add_b        = word_sel(w_b_ext, r_idx);
        if (r_state == INC) begin
            w_add_a = r_t;
            w_add_b = {{(WORD_W-1){1'b0}}, r_carry};
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            IDLE:    if (Start) w_state_d = ADD;
            ADD:     w_state_d = w_skip ? (w_last ? DONE : ADD) : INC;
            INC:     w_state_d = w_last ? DONE : ADD;
            DONE:    w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_work  <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_c1    <= 1'b0;
            r_cout  <= 1'b0;
            r_t     <= '0;
        end else begin
            r_state <= w_state_d;
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_carry <= Cin;
                        r_idx   <= '0;
                    end
                end
                ADD: begin
                    if (w_skip) begin
                        r_work[r_idx*WORD_W +: WORD_W] <= w_sum16;
                        r_carry                        <= w_cout16;
                        if (!w_last) r_idx <= r_idx + 4'd1;
                    end else begin
                        r_t  <= w_sum16;
                        r_c1 <= w_cout16;
                    end
                end
                INC: begin
                    r_work[r_idx*WORD_W +: WORD_W] <= w_sum16;
                    r_carry                        <= r_c1 | w_cout16;
                    if (!w_last) r_idx <= r_idx + 4'd1;
                end
                DONE: begin
                    r_sum  <= r_work;
                    r_cout <= r_carry;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bk16_mp_seq.sv
// Directed bench for bk16_mp_seq (WORDS=4); expected latency follows BK16_SKIP_INC_EN.
module tb_bk16_mp_seq;
    import bk16_mp_pkg::*;

    localparam int unsigned WORDS = 4;

    logic        Clk   = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        Cin   = 1'b0;
    logic [63:0] A     = '0;
    logic [63:0] B     = '0;
    logic        Busy;
    logic        Done;
    logic [63:0] Sum;
    logic        Cout;

    int n_checks = 0;
    int n_fail   = 0;

    bk16_mp_seq #(.WORDS(WORDS)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .Busy  (Busy),
        .Done  (Done),
        .Sum   (Sum),
        .Cout  (Cout)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] sum;
        logic        cout;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [63:0] a, input logic [63:0] b, input logic cin);
`ifdef BK16_SKIP_INC_EN
        int          n = WORDS + 1;
        logic        c = cin;
        logic [16:0] s;
        for (int w = 0; w < WORDS; w++) begin
            if (c) n++;
            s = {1'b0, a[w*16 +: 16]} + {1'b0, b[w*16 +: 16]} + {16'b0, c};
            c = s[16];
        end
        return n;
`else
        return 2 * WORDS + 1;
`endif
    endfunction

    // The partial-sum carry and the increment carry can never both be set.
    always @(negedge Clk) begin
        if (!Reset && dut.r_state == INC) begin
            n_checks++;
            if (dut.r_c1 && dut.w_cout16) begin
                n_fail++;
                $display("FAIL inc_double_carry: c1=%b cout16=%b expected not both 1",
                         dut.r_c1, dut.w_cout16);
            end
        end
    end

    task automatic run_op(input string name, input logic [63:0] a, input logic [63:0] b,
                          input logic cin, input logic [63:0] exp_sum, input logic exp_cout);
        int   lat;
        logic busy_ok;
        @(negedge Clk);
        A = a; B = b; Cin = cin; Start = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) begin
                @(posedge Clk);
                #1;
            end
            if (!Busy) busy_ok = 1'b0;
            if (Done) begin
                lat = k;
                break;
            end
        end
        chk({name, "_latency"}, 64'(lat), 64'(exp_lat(a, b, cin)));
        chk({name, "_busy"}, 64'(busy_ok), 64'd1);
        @(posedge Clk);
        #1;
        chk({name, "_done_pulse"}, 64'(Done), 64'd0);
        chk({name, "_idle"}, 64'(Busy), 64'd0);
        chk({name, "_sum"}, Sum, exp_sum);
        chk({name, "_cout"}, 64'(Cout), 64'(exp_cout));
    endtask

    initial begin
        int done_cnt;
        int l1;
        int l2;
        int lat;

        vecs[0] = '{64'h1, 64'h2, 1'b0, 64'h3, 1'b0};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1};
        vecs[2] = '{64'h0, 64'h0, 1'b1, 64'h1, 1'b0};
        vecs[3] = '{64'h0000_FFFF_0000_FFFF, 64'h1, 1'b0, 64'h0000_FFFF_0001_0000, 1'b0};
        vecs[4] = '{64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0,
                    64'h2345_6789_ABCD_F001, 1'b0};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1};
        vecs[6] = '{64'h8000_8000_8000_8000, 64'h8000_8000_8000_8000, 1'b1,
                    64'h0001_0001_0001_0001, 1'b1};

        repeat (2) @(posedge Clk);
        #1;
        chk("reset_busy", 64'(Busy), 64'd0);
        chk("reset_done", 64'(Done), 64'd0);
        chk("reset_sum", Sum, 64'h0);
        chk("reset_cout", 64'(Cout), 64'd0);
        @(negedge Clk);
        Reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                   vecs[i].sum, vecs[i].cout);
        end

        // Asynchronous reset in the middle of an operation.
        @(negedge Clk);
        A = 64'h1; B = 64'h2; Cin = 1'b0; Start = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        repeat (3) @(posedge Clk);
        #2 Reset = 1'b1;
        #1;
        chk("async_rst_sum", Sum, 64'h0);
        chk("async_rst_cout", 64'(Cout), 64'd0);
        chk("async_rst_busy", 64'(Busy), 64'd0);
        chk("async_rst_done", 64'(Done), 64'd0);
        @(negedge Clk);
        Reset = 1'b0;
        run_op("post_reset", 64'd7, 64'd9, 1'b0, 64'd16, 1'b0);

        // Start while busy is ignored; a Start held across DONE is taken the cycle after.
        l1 = exp_lat(64'd5, 64'd6, 1'b0);
        l2 = exp_lat(64'd100, 64'd100, 1'b0);
        @(negedge Clk);
        A = 64'd5; B = 64'd6; Cin = 1'b0; Start = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        done_cnt = 0;
        for (int k = 1; k <= l1 + 1; k++) begin
            if (k > 1) begin
                @(posedge Clk);
                #1;
            end
            if (Done) done_cnt++;
            if (k == l1) chk("busy_start_done_cycle", 64'(Done), 64'd1);
            if (k == 3) begin
                A = 64'd100; B = 64'd100; Start = 1'b1;
            end
            if (k == 4) Start = 1'b0;
            if (k == l1) Start = 1'b1;
        end
        chk("busy_start_one_done", 64'(done_cnt), 64'd1);
        chk("busy_start_idle", 64'(Busy), 64'd0);
        chk("busy_start_sum", Sum, 64'hB);
        @(posedge Clk);
        #1 Start = 1'b0;
        chk("busy_start_accept", 64'(Busy), 64'd1);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) begin
                @(posedge Clk);
                #1;
            end
            if (Done) begin
                lat = k;
                break;
            end
        end
        chk("busy_start_2nd_latency", 64'(lat), 64'(l2));
        @(posedge Clk);
        #1;
        chk("busy_start_2nd_sum", Sum, 64'd200);
        chk("busy_start_2nd_cout", 64'(Cout), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bk16_mp_seq.md
Name: bk16_mp_seq

Overview:
- Multi-precision add sequencer built around one shared bk16 16-bit Brent-Kung adder (ports Sum, Cout, A, B; no carry-in).
- Computes a (16*WORDS)-bit sum, least significant word first.
- bk16 has no carry-in, so each word takes two phases: ADD (A_word + B_word), then INC (partial sum + carry).
- Start/Done handshake; result registered and held until the next accepted operation completes.

Parameters:
- WORDS, 4, number of 16-bit words per operand (total width 16*WORDS); legal range 1..16.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  request; sampled only in IDLE.
- A  input  16*WORDS  operand A; latched on the accepted Start.
- B  input  16*WORDS  operand B; latched on the accepted Start.
- Cin  input  1  initial carry into word 0; latched on the accepted Start.
- Busy  output  1  high whenever state != IDLE.
- Done  output  1  one-cycle pulse; result valid.
- Sum  output  16*WORDS  registered result.
- Cout  output  1  registered carry out of the top word.

Behaviour:
- Reset (async, any state): state=IDLE, idx=0, carry=0, working regs=0, Sum=0, Cout=0, Done=0, Busy=0. An operation in flight is discarded. First Start is accepted on the first rising edge after Reset deasserts.
- FSM states: IDLE, ADD, INC, DONE.
- IDLE:
  - Start=1: latch A, B into operand regs; carry<=Cin; idx<=0; go to ADD.
  - Otherwise stay in IDLE.
- ADD:
  - bk16 inputs = A_word[idx], B_word[idx].
  - t<=Sum16; c1<=Cout16; go to INC.
- INC:
  - bk16 inputs = t, {15'b0, carry}.
  - work_word[idx]<=Sum16; carry<=c1|Cout16.
  - c1 and Cout16 are never both 1; the bench asserts this.
  - If idx==WORDS-1 go to DONE; else idx<=idx+1 and go to ADD.
- DONE:
  - Sum<=work; Cout<=carry; Done=1 for exactly this cycle; go to IDLE.
- Adder input mux is selected purely by state; one bk16 instance only.
- Latency: Start sampled at edge 0 gives Done high in cycle 2*WORDS+1. For WORDS=4 that is 9 cycles.
- Start while Busy, including the DONE cycle: ignored, no queuing. Operands may change freely while Busy.
- Sum/Cout change only in DONE; they are stable between Done pulses.
- Width rule: all word arithmetic is mod 2^16; carry is 1 bit; no saturation.
- WORDS=1 is legal: ADD, INC, DONE.

Optional Feature:
- Macro: BK16_SKIP_INC_EN.
- Defined:
  - In ADD, if carry==0, write Sum16 directly to work_word[idx], set carry<=Cout16, and advance (to ADD, or to DONE on the last word). INC is skipped.
  - Latency becomes WORDS + (number of words entered with carry=1) + 1 cycles.
- Undefined: fixed 2*WORDS+1 latency, as specified above.
- Results are bit-identical either way.

Decomposition:
- Package bk16_mp_pkg:
  - WORD_W=16 constant.
  - state_t enum {IDLE, ADD, INC, DONE}.
  - Function word_sel(vector, idx) for word extraction.
- Sub-module: the existing bk16, instantiated once and shared between phases. No new sub-module is needed; FSM and datapath registers live in bk16_mp_seq.

Test Plan (WORDS=4):
- A=64'h1, B=64'h2, Cin=0, Start pulse -> Sum=64'h3, Cout=0; Done exactly 9 cycles after Start; Busy high cycles 1-9.
- A=64'hFFFF_FFFF_FFFF_FFFF, B=64'h1, Cin=0 -> Sum=0, Cout=1 (carry ripples through every INC phase).
- A=B=64'h8000_8000_8000_8000, Cin=1 -> Sum=64'h0001_0001_0001_0001, Cout=1.
- Start with A=5, B=6; at cycle 3 assert Start with A=100, B=100; also hold Start=1 during the DONE cycle -> Sum=64'hB, exactly one Done pulse; the re-asserted Start is accepted only on the cycle after Done.
- Assert Reset at cycle 4 of an operation -> Sum=0, Cout=0, Busy=0, Done=0 immediately (asynchronous). Release Reset, then Start A=7, B=9 -> Sum=16, Done after 9 cycles.
- With BK16_SKIP_INC_EN defined:
  - A=64'h1, B=64'h2 -> Done after 5 cycles.
  - A=64'hFFFF_FFFF_FFFF_FFFF, B=64'h1, Cin=0 -> Sum=0, Cout=1, Done after 8 cycles.
